// File: rtl/img2col_sched_pkg.sv
// Shared types for the img2col layer scheduler: Data_Generate config bus,
// host layer descriptor layout and scheduler FSM states.
package img2col_sched_pkg;

  localparam int BEAT_W_DEF = 32;

  typedef struct packed {
    logic [7:0]  stride;
    logic [7:0]  kernel;
    logic [7:0]  window;
    logic [15:0] in_size;
    logic [15:0] in_ch;
    logic [15:0] out_ch;
    logic [15:0] out_ch_times;
    logic [15:0] out_size;
    logic [15:0] outcol_times;
    logic [15:0] outrow_times;
    logic [15:0] incol_times;
  } dg_cfg_t;

  localparam int CFG_W = $bits(dg_cfg_t);

  // Descriptor as seen on desc_data: cfg in the MSBs, then in_beats, then out_beats.
  typedef struct packed {
    dg_cfg_t                cfg;
    logic [BEAT_W_DEF-1:0]  in_beats;
    logic [BEAT_W_DEF-1:0]  out_beats;
  } layer_desc_t;

  localparam int DESC_W = $bits(layer_desc_t);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/img2col_layer_scheduler_fifo.sv
// Synchronous descriptor FIFO with registered occupancy count.
// A pop frees its slot for pushes only from the following cycle.
module sched_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/img2col_layer_scheduler.sv
// Layer scheduler for the img2col Data_Generate datapath: queues descriptors,
// drives the static config and start level, meters input beats, counts output
// beats, flags layer boundaries and watches for stalls.
module img2col_layer_scheduler
  import img2col_sched_pkg::*;
#(
  parameter int DESC_DEPTH = 4,
  parameter int BEAT_W     = 32,
  parameter int TIMEOUT    = 65536
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  logic [CFG_W+2*BEAT_W-1:0] desc_data,
  input  logic                      src_valid,
  output logic                      src_ready,
  output logic                      dg_in_valid,
  input  logic                      dg_in_ready,
  input  logic                      dg_out_valid,
  input  logic                      dg_out_ready,
  output logic [CFG_W-1:0]          dg_cfg,
  output logic                      dg_start,
  output logic                      out_last,
  output logic                      layer_done,
  output logic                      busy,
  output logic [7:0]                layer_idx,
  output logic                      err
);

  localparam int DW = CFG_W + 2*BEAT_W;
  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_e      state_q, state_d;
  logic [BEAT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [BEAT_W-1:0] in_beats_q, in_beats_d, out_beats_q, out_beats_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [7:0]        idx_q, idx_d;
  logic [TW-1:0]     wd_q, wd_d;
  logic              err_q, err_d;

  logic [DW-1:0]     fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [BEAT_W-1:0] head_in, head_out;
  logic [CFG_W-1:0]  head_cfg;
  logic              active, gate, in_hs, out_hs, last_beat, load_next;

  sched_desc_fifo #(
    .DEPTH (DESC_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (desc_valid),
    .wdata_i (desc_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_cfg = fifo_rdata[DW-1 -: CFG_W];
  assign head_in  = fifo_rdata[2*BEAT_W-1:BEAT_W];
  assign head_out = fifo_rdata[BEAT_W-1:0];
  assign fifo_pop = (state_q == S_LOAD);

  assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign gate      = (state_q == S_RUN) && (in_cnt_q < in_beats_q);
  assign in_hs     = dg_in_valid & dg_in_ready;
  assign out_hs    = dg_out_valid & dg_out_ready & active;
  assign last_beat = (out_cnt_q == out_beats_q - BEAT_W'(1));

  assign src_ready   = dg_in_ready & gate;
  assign dg_in_valid = src_valid & gate;
  assign out_last    = dg_out_valid & active & last_beat;
  assign desc_ready  = ~fifo_full;
  assign dg_cfg      = cfg_q;
  assign dg_start    = active;
  assign layer_done  = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign layer_idx   = idx_q;
  assign err         = err_q;

  // Next-state: FSM sequencing, beat counters, descriptor latch and watchdog.
  // The descriptor is latched on entry to LOAD so dg_cfg is already valid
  // during LOAD; the FIFO pop itself happens at the end of LOAD.
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    in_beats_d  = in_beats_q;
    out_beats_d = out_beats_q;
    cfg_d       = cfg_q;
    idx_d       = idx_q;
    wd_d        = wd_q;
    err_d       = err_q;
    load_next   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d   = S_LOAD;
          load_next = 1'b1;
        end
      end
      S_LOAD:  state_d = S_RUN;
      S_RUN: begin
        if (out_hs && last_beat)        state_d = S_DONE;
        else if (in_cnt_q == in_beats_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_hs && last_beat) state_d = S_DONE;
      end
      S_DONE: begin
        idx_d = idx_q + 8'd1;
        if (!fifo_empty) begin
          state_d   = S_LOAD;
          load_next = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (in_hs)  in_cnt_d  = in_cnt_q + BEAT_W'(1);
    if (out_hs) out_cnt_d = out_cnt_q + BEAT_W'(1);
    if (state_d == S_DONE && state_q != S_DONE) in_cnt_d = in_beats_q;

    if (load_next) begin
      cfg_d       = head_cfg;
      in_beats_d  = (head_in  == '0) ? BEAT_W'(1) : head_in;
      out_beats_d = (head_out == '0) ? BEAT_W'(1) : head_out;
      in_cnt_d    = '0;
      out_cnt_d   = '0;
    end

    if (in_hs || out_hs || (state_d != state_q)) wd_d = '0;
    else if (active && wd_q != TW'(TIMEOUT))     wd_d = wd_q + TW'(1);
    if (active && wd_d == TW'(TIMEOUT))          err_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      in_beats_q  <= '0;
      out_beats_q <= '0;
      cfg_q       <= '0;
      idx_q       <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      in_beats_q  <= in_beats_d;
      out_beats_q <= out_beats_d;
      cfg_q       <= cfg_d;
      idx_q       <= idx_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_img2col_layer_scheduler.sv
// Bench for img2col_layer_scheduler: directed layers against a queue-based
// reference of the scheduling rules, plus hand-computed literal expectations.
module tb_img2col_layer_scheduler;
  import img2col_sched_pkg::*;

  localparam int DEPTH = 4;
  localparam int BW    = 32;
  localparam int TMO   = 100;
  localparam int DW    = CFG_W + 2*BW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              desc_valid = 1'b0;
  logic              desc_ready;
  logic [DW-1:0]     desc_data = '0;
  logic              src_valid = 1'b0;
  logic              src_ready;
  logic              dg_in_valid;
  logic              dg_in_ready = 1'b1;
  logic              dg_out_valid = 1'b0;
  logic              dg_out_ready = 1'b1;
  logic [CFG_W-1:0]  dg_cfg;
  logic              dg_start, out_last, layer_done, busy, err;
  logic [7:0]        layer_idx;

  img2col_layer_scheduler #(
    .DESC_DEPTH (DEPTH),
    .BEAT_W     (BW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_data    (desc_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .dg_in_valid  (dg_in_valid),
    .dg_in_ready  (dg_in_ready),
    .dg_out_valid (dg_out_valid),
    .dg_out_ready (dg_out_ready),
    .dg_cfg       (dg_cfg),
    .dg_start     (dg_start),
    .out_last     (out_last),
    .layer_done   (layer_done),
    .busy         (busy),
    .layer_idx    (layer_idx),
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic dg_cfg_t mk_cfg(input int s, input int k, input int insz, input int ch,
                                      input int och, input int otimes, input int osz);
    dg_cfg_t c;
    c.stride       = 8'(s);
    c.kernel       = 8'(k);
    c.window       = 8'(k);
    c.in_size      = 16'(insz);
    c.in_ch        = 16'(ch);
    c.out_ch       = 16'(och);
    c.out_ch_times = 16'(otimes);
    c.out_size     = 16'(osz);
    c.outcol_times = 16'(osz);
    c.outrow_times = 16'(osz);
    c.incol_times  = 16'(insz / s);
    return c;
  endfunction

  function automatic logic [DW-1:0] mk_desc(input dg_cfg_t c, input int unsigned ib, input int unsigned ob);
    return {c, ib, ob};
  endfunction

  // Reference: a layer is idle, loading (one cycle), active, or finishing (one
  // cycle). Descriptors wait in an ordered queue whose occupancy is seen one
  // cycle after a push; a layer ends on its out_beats-th output handshake.
  typedef enum int {PH_IDLE, PH_LOAD, PH_ACTIVE, PH_FIN} phase_e;
  phase_e           m_phase = PH_IDLE;
  logic [DW-1:0]    m_q[$];
  logic [CFG_W-1:0] m_cfg = '0;
  int unsigned      m_in = 0, m_out = 0, m_inb = 1, m_outb = 1;
  int unsigned      m_idx = 0;

  // Observations of the DUT for the literal checks.
  int unsigned mon_in = 0, mon_out = 0, mon_done = 0, mon_last_at = 0;
  int unsigned done_stride[$];

  logic        e_gate, e_in_hs, e_out_hs, e_push;
  logic [DW-1:0] hd;

  // Per-cycle comparison of every output against the reference, then advance.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = PH_IDLE; m_q.delete(); m_cfg = '0;
      m_in = 0; m_out = 0; m_inb = 1; m_outb = 1; m_idx = 0;
    end else begin
      e_gate = (m_phase == PH_ACTIVE) && (m_in < m_inb);
      chk("busy",        busy,        m_phase != PH_IDLE);
      chk("dg_start",    dg_start,    m_phase == PH_ACTIVE);
      chk("src_ready",   src_ready,   dg_in_ready & e_gate);
      chk("dg_in_valid", dg_in_valid, src_valid & e_gate);
      chk("out_last",    out_last,    dg_out_valid && (m_phase == PH_ACTIVE) && (m_out + 1 == m_outb));
      chk("layer_done",  layer_done,  m_phase == PH_FIN);
      chk("layer_idx",   layer_idx,   m_idx);
      chk("dg_cfg",      dg_cfg,      m_cfg);
      chk("desc_ready",  desc_ready,  m_q.size() < DEPTH);

      if (dg_in_valid && dg_in_ready) mon_in++;
      if (dg_out_valid && dg_out_ready && dg_start) begin
        mon_out++;
        if (out_last) mon_last_at = mon_out;
      end
      if (layer_done) begin
        mon_done++;
        done_stride.push_back(int'(dg_cfg[CFG_W-1 -: 8]));
      end

      e_in_hs  = src_valid && dg_in_ready && e_gate;
      e_out_hs = dg_out_valid && dg_out_ready && (m_phase == PH_ACTIVE);
      e_push   = desc_valid && (m_q.size() < DEPTH);
      case (m_phase)
        PH_IDLE: if (m_q.size() > 0) begin
          hd = m_q[0];
          m_cfg = hd[DW-1 -: CFG_W];
          m_inb = (hd[2*BW-1:BW] == 0) ? 1 : hd[2*BW-1:BW];
          m_outb = (hd[BW-1:0] == 0) ? 1 : hd[BW-1:0];
          m_in = 0; m_out = 0; m_phase = PH_LOAD;
        end
        PH_LOAD: begin
          void'(m_q.pop_front());
          m_phase = PH_ACTIVE;
        end
        PH_ACTIVE: begin
          if (e_in_hs) m_in++;
          if (e_out_hs) begin
            m_out++;
            if (m_out == m_outb) m_phase = PH_FIN;
          end
        end
        PH_FIN: begin
          m_idx = (m_idx + 1) % 256;
          if (m_q.size() > 0) begin
            hd = m_q[0];
            m_cfg = hd[DW-1 -: CFG_W];
            m_inb = (hd[2*BW-1:BW] == 0) ? 1 : hd[2*BW-1:BW];
            m_outb = (hd[BW-1:0] == 0) ? 1 : hd[BW-1:0];
            m_in = 0; m_out = 0; m_phase = PH_LOAD;
          end else begin
            m_phase = PH_IDLE;
          end
        end
        default: m_phase = PH_IDLE;
      endcase
      if (e_push) m_q.push_back(desc_data);
    end
  end

  // Tasks enter and leave at posedge+1.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic push_desc(input logic [DW-1:0] d);
    bit ok = 0;
    bit r;
    desc_valid = 1'b1;
    desc_data  = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); r = desc_ready;
      @(posedge clk); #1;
      if (r) ok = 1;
    end
    desc_valid = 1'b0;
    if (!ok) chk("push_timeout", 1'b0, 1'b1);
  endtask

  // Drive src/out until done_target layers completed; out beats either
  // immediately or only once in_target input beats have been seen.
  task automatic run_layers(input int unsigned done_target, input int on_c, input int off_c,
                            input bit out_after_in, input int unsigned in_target, input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      if (mon_done >= done_target) break;
      src_valid    = ((k % (on_c + off_c)) < on_c);
      dg_out_valid = out_after_in ? (mon_in >= in_target) : 1'b1;
      @(posedge clk); #1;
    end
    src_valid = 1'b0; dg_out_valid = 1'b0;
    if (mon_done < done_target) chk("run_timeout", 32'(mon_done), 32'(done_target));
  endtask

  int unsigned base_in, base_out;
  dg_cfg_t     c_vit;

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset state.
    cycles(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_idx", layer_idx, 8'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_desc_ready", desc_ready, 1'b1);
    chk("rst_cfg", dg_cfg, '0);
    rst_n = 1'b1;
    cycles(2);

    // Layer 1: 16 in, 8 out, src always valid, outputs start after all inputs.
    base_in = mon_in; base_out = mon_out;
    push_desc(mk_desc(mk_cfg(1, 3, 32, 8, 16, 1, 30), 16, 8));
    run_layers(1, 1, 0, 1'b1, base_in + 16, 200);
    cycles(2);
    chk("l1_in_beats", 32'(mon_in - base_in), 32'd16);
    chk("l1_out_beats", 32'(mon_out - base_out), 32'd8);
    chk("l1_last_at", 32'(mon_last_at - base_out), 32'd8);
    chk("l1_idx", layer_idx, 8'd1);

    // ViT-shaped patch layer, scaled beat count, 64-on/30-off source duty.
    c_vit = mk_cfg(16, 16, 224, 3, 768, 96, 14);
    base_in = mon_in;
    push_desc(mk_desc(c_vit, 256, 4));
    run_layers(2, 64, 30, 1'b1, base_in + 256, 2000);
    cycles(2);
    chk("vit_in_beats", 32'(mon_in - base_in), 32'd256);
    chk("vit_cfg_stride", done_stride[1], 32'd16);
    chk("vit_idx", layer_idx, 8'd2);

    // Fill the FIFO behind a stalled layer; fifth offer must be refused.
    push_desc(mk_desc(mk_cfg(1, 1, 8, 1, 1, 1, 8), 3, 2));
    cycles(3);
    push_desc(mk_desc(mk_cfg(2, 1, 8, 1, 1, 1, 4), 3, 2));
    push_desc(mk_desc(mk_cfg(3, 1, 9, 1, 1, 1, 3), 3, 2));
    push_desc(mk_desc(mk_cfg(4, 1, 8, 1, 1, 1, 2), 3, 2));
    push_desc(mk_desc(mk_cfg(5, 1, 5, 1, 1, 1, 1), 0, 0));
    desc_valid = 1'b1;
    desc_data  = mk_desc(mk_cfg(9, 9, 9, 9, 9, 9, 9), 1, 1);
    @(negedge clk);
    chk("fifo_full_ready", desc_ready, 1'b0);
    @(posedge clk); #1;
    desc_valid = 1'b0;
    run_layers(7, 1, 0, 1'b0, 0, 300);
    cycles(2);
    chk("order_0", done_stride[2], 32'd1);
    chk("order_1", done_stride[3], 32'd2);
    chk("order_4", done_stride[6], 32'd5);
    chk("fifo_idx", layer_idx, 8'd7);

    // Outputs finish before inputs: 2 out beats end the layer early.
    base_in = mon_in;
    push_desc(mk_desc(mk_cfg(7, 2, 16, 2, 2, 1, 8), 10, 2));
    run_layers(8, 1, 0, 1'b0, 0, 100);
    src_valid = 1'b1;
    cycles(4);
    src_valid = 1'b0;
    chk("early_in_beats", 32'(mon_in - base_in), 32'd2);
    chk("early_idx", layer_idx, 8'd8);

    // Asynchronous reset in the middle of a running layer.
    push_desc(mk_desc(mk_cfg(6, 2, 16, 2, 2, 1, 8), 20, 4));
    src_valid = 1'b1;
    cycles(8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_src_ready", src_ready, 1'b0);
    chk("arst_dg_in_valid", dg_in_valid, 1'b0);
    chk("arst_dg_start", dg_start, 1'b0);
    chk("arst_cfg", dg_cfg, '0);
    chk("arst_idx", layer_idx, 8'd0);
    src_valid = 1'b0;
    @(posedge clk); #1;
    cycles(1);
    rst_n = 1'b1;
    cycles(1);
    base_in = mon_in; base_out = mon_out;
    push_desc(mk_desc(mk_cfg(8, 2, 16, 2, 2, 1, 8), 5, 2));
    run_layers(mon_done + 1, 1, 0, 1'b1, base_in + 5, 100);
    cycles(2);
    chk("arst_in_beats", 32'(mon_in - base_in), 32'd5);
    chk("arst_last_at", 32'(mon_last_at - base_out), 32'd2);
    chk("arst_new_idx", layer_idx, 8'd1);

    // Watchdog: output never arrives; err after TIMEOUT idle cycles, sticky.
    base_in = mon_in;
    push_desc(mk_desc(mk_cfg(11, 1, 4, 1, 1, 1, 4), 1, 1));
    src_valid = 1'b1;
    for (int k = 0; k < 20 && mon_in == base_in; k++) cycles(1);
    src_valid = 1'b0;
    chk("wd_in_seen", 32'(mon_in - base_in), 32'd1);
    push_desc(mk_desc(mk_cfg(12, 1, 4, 1, 1, 1, 4), 1, 1));
    cycles(85);
    chk("wd_err_early", err, 1'b0);
    cycles(30);
    chk("wd_err_set", err, 1'b1);
    chk("wd_still_busy", busy, 1'b1);
    cycles(20);
    chk("wd_err_sticky", err, 1'b1);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(8);
    chk("wd_rst_err", err, 1'b0);
    chk("wd_rst_fifo_empty", busy, 1'b0);
    chk("wd_rst_idx", layer_idx, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
